mult_booth_seq: RTL and testbench
=================================

# mult_booth_seq

Signed 32x32 sequential multiplier using radix-2 Booth recoding, producing a 64-bit two's-complement product. It is the multi-cycle multiply engine of the ALU datapath. A one-cycle `start` pulse launches an operation. `done` flags a stable `result` until the next accepted `start`.

## Interface
- `WIDTH`, default 32: operand width. The product is 2*WIDTH bits. Only 32 is verified.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled on the rising edge of `clk`.
- `M` in WIDTH: multiplicand, signed two's complement.
- `Q` in WIDTH: multiplier, signed two's complement.
- `result` out 2*WIDTH: signed product, registered.
- `done` out 1: level-high completion flag, registered.

## Operation
- States:
  - IDLE: after reset only.
  - BUSY: iterating.
  - DONE: result valid.
- Transitions:
  - IDLE to BUSY on `start`.
  - BUSY to DONE after WIDTH iterations.
  - DONE to BUSY on `start`.
  - `start` in BUSY is ignored; no restart and no queuing.
- Load (on the accepting edge):
  - Internal registers: accumulator A (WIDTH+1 bits) = 0, Qr = `Q`, q_m1 = 0.
  - Mr = `M` sign-extended to WIDTH+1 bits; count = WIDTH.
  - `done` is cleared. `result` is unchanged.
- Each BUSY cycle, examine {Qr[0], q_m1}:
  - 01: A = A + Mr.
  - 10: A = A - Mr.
  - 00 or 11: no change.
  - Then arithmetic right shift of {A, Qr, q_m1} by 1; A's MSB is replicated. Decrement count.
- The accumulator is WIDTH+1 bits so that M = -2^31 (subtract causes +2^31) never overflows. All add/sub is modulo 2^(WIDTH+1).
- Completion (edge of the last iteration):
  - `result` = {A[WIDTH-1:0], Qr}.
  - `done` = 1.
  - Enter DONE.
- `result` and `done` hold in DONE indefinitely. Operands may change freely after the accepting edge without affecting the operation.
- Exact for every signed operand pair, including both equal to -2^31.

## Timing
- Reset asserted (low), at any time including mid-operation:
  - Immediately: `result` = 0, `done` = 0, state IDLE.
  - Counters and datapath registers cleared; any in-flight operation is discarded.
- Latency: `start` accepted at edge N gives `done` = 1 and a valid `result` after edge N+WIDTH (32 cycles).
- `done` falls at the edge that accepts a new `start`. It is therefore 0 throughout BUSY.
- `start` held high for several cycles:
  - Accepted once at the first edge in IDLE/DONE; ignored while BUSY.
  - If still high when DONE is reached, it is re-accepted on the next edge. This gives one DONE cycle, then a new operation with the current operands.
- Back-to-back: `start` may be asserted in the first DONE cycle; there is no dead cycle requirement.
- No combinational path from inputs to outputs.

## Structure
- Shared package `mult_pkg`: `WIDTH` default constant and the state enum (IDLE, BUSY, DONE).
- One sub-module: `booth_step`, combinational.
  - Inputs: {A, Qr, q_m1}, Mr.
  - Output: the next {A, Qr, q_m1} after add/sub and the arithmetic shift.
- Top level holds the FSM, count register and output registers.

## Test plan
- 12345 x 6789, one-cycle `start`: `done` rises exactly 32 cycles later, `result` = 83810205. Repeat with -12345 x 6789, giving -83810205, and -12345 x -6789, giving 83810205.
- Extremes:
  - -2^31 x -2^31 gives 4611686018427387904.
  - 2147483647 x -2^31 gives -4611686016279904256.
  - 2147483647 x 2147483647 gives 4611686014132420609.
- Identity and zero:
  - 0 x 123456789 gives 0.
  - 2147483647 x -1 gives -2147483647.
  - -2^31 x 1 gives -2147483648.
- 12345678 x -87654321 gives -1082152022374638. Then issue `start` in the first DONE cycle with 987654321 x 123456789:
  - `done` drops on the accepting edge.
  - 121932631112635269 is produced 32 cycles later.
- Pulse `start` again 10 cycles into an operation with different operands: the pulse is ignored, and the original product appears at cycle 32.
- Assert `rst` low mid-operation:
  - `result` and `done` go to 0 immediately, without a clock edge.
  - After release, `done` stays 0 until a new `start`, which completes correctly.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and FSM state encoding for the sequential Booth multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of Mr into A, then an
// arithmetic right shift of the combined {A, Qr, q_m1} register.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] qr,
  input  logic             q_m1,
  input  logic [WIDTH:0]   mr,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] qr_next,
  output logic             q_m1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case ({qr[0], q_m1})
      2'b01:   sum = a + mr;
      2'b10:   sum = a - mr;
      default: sum = a;
    endcase
    // Replicating the sign of the WIDTH+1 bit accumulator keeps the shift exact.
    {a_next, qr_next, q_m1_next} = {sum[WIDTH], sum, qr};
  end

endmodule

// File: rtl/mult_booth_seq.sv
// Signed WIDTH x WIDTH sequential radix-2 Booth multiplier; one iteration per
// clock, result and done registered and held until the next accepted start.
module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH:0]   mr_reg;
  logic [WIDTH-1:0] qr_reg;
  logic             q_m1_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic             done_reg;

  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] qr_next;
  logic             q_m1_next;
  logic             accept;

  // A start seen while iterating is dropped, never queued.
  assign accept = start && (state_reg != BUSY);

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a         (a_reg),
    .qr        (qr_reg),
    .q_m1      (q_m1_reg),
    .mr        (mr_reg),
    .a_next    (a_next),
    .qr_next   (qr_next),
    .q_m1_next (q_m1_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      a_reg      <= '0;
      mr_reg     <= '0;
      qr_reg     <= '0;
      q_m1_reg   <= 1'b0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else if (accept) begin
      state_reg <= BUSY;
      count_reg <= CW'(WIDTH);
      a_reg     <= '0;
      mr_reg    <= {M[WIDTH-1], M};
      qr_reg    <= Q;
      q_m1_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (state_reg == BUSY) begin
      a_reg     <= a_next;
      qr_reg    <= qr_next;
      q_m1_reg  <= q_m1_next;
      count_reg <= count_reg - CW'(1);
      if (count_reg == CW'(1)) begin
        result_reg <= {a_next[WIDTH-1:0], qr_next};
        done_reg   <= 1'b1;
        state_reg  <= DONE;
      end
    end
  end

  assign result = result_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed checks of mult_booth_seq: product table, latency, back-to-back,
// ignored mid-operation start and asynchronous reset.
module tb_mult_booth_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] M;
  logic [31:0] Q;
  logic [63:0] result;
  logic        done;

  int checks;
  int errors;

  mult_booth_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .M      (M),
    .Q      (Q),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  // Launch an operation and wait for done; optionally poke start mid-flight.
  task automatic do_op(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp,
                       input int poke_at, input string name);
    int cycles;
    @(negedge clk);
    M = m;
    Q = q;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    M = 32'h5a5a_1234;
    Q = 32'hdead_beef;
    check64({name, "_done_low_on_accept"}, {63'd0, done}, 64'd0);
    cycles = 0;
    while (!done && cycles < 40) begin
      if (cycles == poke_at) begin
        @(negedge clk);
        start = 1'b1;
        M = 32'd7;
        Q = 32'd9;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
    end
    check64({name, "_latency"}, 64'(cycles), 64'd32);
    check64({name, "_product"}, result, exp);
    $display("op %s: %0d x %0d -> %0d after %0d cycles", name, $signed(m), $signed(q),
             $signed(result), cycles);
  endtask

  initial begin
    int high_seen;
    logic [63:0] held;
    checks = 0;
    errors = 0;
    start = 1'b0;
    M = '0;
    Q = '0;

    vecs[0] = '{32'd12345, 32'd6789, 64'd83810205};
    vecs[1] = '{-32'sd12345, 32'd6789, -64'sd83810205};
    vecs[2] = '{-32'sd12345, -32'sd6789, 64'd83810205};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'd4611686018427387904};
    vecs[4] = '{32'd2147483647, 32'h8000_0000, -64'sd4611686016279904256};
    vecs[5] = '{32'd2147483647, 32'd2147483647, 64'd4611686014132420609};
    vecs[6] = '{32'd0, 32'd123456789, 64'd0};
    vecs[7] = '{32'd2147483647, 32'hffff_ffff, -64'sd2147483647};
    vecs[8] = '{32'h8000_0000, 32'd1, -64'sd2147483648};
    vecs[9] = '{32'd12345678, -32'sd87654321, -64'sd1082152022374638};

    rst = 1'b0;
    #1;
    check64("reset_result", result, 64'd0);
    check64("reset_done", {63'd0, done}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check64("idle_done_low", {63'd0, done}, 64'd0);

    // Each call launches in the first DONE cycle of the previous one.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].m, vecs[i].q, vecs[i].exp, -1, $sformatf("vec%0d", i));
    end
    do_op(32'd987654321, 32'd123456789, 64'd121932631112635269, -1, "back_to_back");

    held = result;
    repeat (5) @(posedge clk);
    #1;
    check64("hold_done", {63'd0, done}, 64'd1);
    check64("hold_result", result, held);

    do_op(32'd1000, -32'sd3, -64'sd3000, 10, "ignored_start");

    // Reset mid-operation must clear outputs without waiting for an edge.
    @(negedge clk);
    M = 32'd55;
    Q = 32'd66;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check64("async_rst_result", result, 64'd0);
    check64("async_rst_done", {63'd0, done}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    high_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) high_seen = 1;
    end
    check64("post_rst_done_stays_low", 64'(high_seen), 64'd0);
    do_op(-32'sd77, 32'd1001, -64'sd77077, -1, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
